// File: rtl/pwl_activation_piped.sv
// pwl_activation_piped
//   Handshaked piecewise-linear activation: y = m[i]*x + c[i], where i is the
//   number of breakpoints that x meets or exceeds. Three pipeline stages
//   (select, multiply, add) share one global advance, so the whole pipe
//   stalls together when the output is held.
//
//   Reset loads the 9-segment sigmoid tables (NSEG=9). Other NSEG values
//   reset every table entry to zero. Tables are reloaded through cfg_*.
//
//   Optional build macro: PWL_SATURATE_EN -- when defined, the product and
//   sum narrowings clamp to the signed BITSIZE range; otherwise they wrap.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       input handshake, in_data is signed x
//   out_valid/out_ready     output handshake, out_data is signed y
//   cfg_we                  table write strobe
//   cfg_sel                 0 breakpoint, 1 slope, 2 intercept, 3 ignored
//   cfg_addr, cfg_wdata     table index and value
module pwl_activation_piped #(
  parameter int BITSIZE = 16,
  parameter int FRAC    = 11,
  parameter int NSEG    = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [BITSIZE-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [BITSIZE-1:0] out_data,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_sel,
  input  logic [$clog2(NSEG)-1:0]   cfg_addr,
  input  logic [BITSIZE-1:0]        cfg_wdata
);
  localparam int AW = $clog2(NSEG);
  localparam int PW = 2 * BITSIZE;

  function automatic logic signed [BITSIZE-1:0] bp_init(input int k);
    logic [15:0] v;
    v = 16'h0000;
    if (NSEG == 9) begin
      case (k)
        0: v = 16'hDC76;  1: v = 16'hE887;  2: v = 16'hF0B3;  3: v = 16'hF7A7;
        4: v = 16'h0859;  5: v = 16'h0F4D;  6: v = 16'h1779;  7: v = 16'h238A;
        default: v = 16'h0000;
      endcase
    end
    return BITSIZE'($signed(v));
  endfunction

  function automatic logic signed [BITSIZE-1:0] m_init(input int k);
    logic [15:0] v;
    v = 16'h0000;
    if (NSEG == 9) begin
      case (k)
        0, 8: v = 16'h0006;
        1, 7: v = 16'h0034;
        2, 6: v = 16'h009C;
        3, 5: v = 16'h0136;
        4:    v = 16'h01D6;
        default: v = 16'h0000;
      endcase
    end
    return BITSIZE'($signed(v));
  endfunction

  function automatic logic signed [BITSIZE-1:0] c_init(input int k);
    logic [15:0] v;
    v = 16'h0000;
    if (NSEG == 9) begin
      case (k)
        0: v = 16'h0034;  1: v = 16'h0102;  2: v = 16'h0233;  3: v = 16'h0359;
        4: v = 16'h03FF;  5: v = 16'h04A6;  6: v = 16'h05CC;  7: v = 16'h06FD;
        8: v = 16'h07CB;
        default: v = 16'h0000;
      endcase
    end
    return BITSIZE'($signed(v));
  endfunction

  // Clamp when the discarded high bits are not a pure sign extension.
  function automatic logic signed [BITSIZE-1:0] narrow(input logic signed [PW-1:0] v);
`ifdef PWL_SATURATE_EN
    logic [PW-BITSIZE:0] hi;
    hi = v[PW-1:BITSIZE-1];
    if (!(&hi) && (|hi))
      return v[PW-1] ? {1'b1, {(BITSIZE-1){1'b0}}} : {1'b0, {(BITSIZE-1){1'b1}}};
`endif
    return v[BITSIZE-1:0];
  endfunction

  logic signed [BITSIZE-1:0] bp_tbl [NSEG-1];
  logic signed [BITSIZE-1:0] m_tbl  [NSEG];
  logic signed [BITSIZE-1:0] c_tbl  [NSEG];

  logic                      advance;
  logic [AW-1:0]             seg;
  logic signed [BITSIZE-1:0] m_sel, c_sel;
  logic signed [PW-1:0]      prod_full, prod_shift;
  logic signed [BITSIZE:0]   sum_w;

  logic                      vld_p0, vld_p1, vld_p2;
  logic signed [BITSIZE-1:0] x_p0, m_p0, c_p0;
  logic signed [BITSIZE-1:0] prod_p1, c_p1;
  logic signed [BITSIZE-1:0] y_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NSEG-1; k++) bp_tbl[k] <= bp_init(k);
      for (int k = 0; k < NSEG; k++) begin
        m_tbl[k] <= m_init(k);
        c_tbl[k] <= c_init(k);
      end
    end else if (cfg_we) begin
      for (int k = 0; k < NSEG-1; k++)
        if (cfg_sel == 2'd0 && cfg_addr == AW'(k)) bp_tbl[k] <= cfg_wdata;
      for (int k = 0; k < NSEG; k++) begin
        if (cfg_sel == 2'd1 && cfg_addr == AW'(k)) m_tbl[k] <= cfg_wdata;
        if (cfg_sel == 2'd2 && cfg_addr == AW'(k)) c_tbl[k] <= cfg_wdata;
      end
    end
  end

  assign advance   = !vld_p2 || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p2;
  assign out_data  = y_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      y_p2   <= '0;
    end else if (advance) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (vld_p1) y_p2 <= narrow(PW'(sum_w));
    end
  end

  // Stage 1: segment select and table read
  always_comb begin
    seg = '0;
    for (int k = 0; k < NSEG-1; k++)
      if (in_data >= bp_tbl[k]) seg = seg + AW'(1);
    m_sel = '0;
    c_sel = '0;
    for (int k = 0; k < NSEG; k++)
      if (seg == AW'(k)) begin
        m_sel = m_tbl[k];
        c_sel = c_tbl[k];
      end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      x_p0 <= in_data;
      m_p0 <= m_sel;
      c_p0 <= c_sel;
    end
  end

  // Stage 2: full-width product, floor shift, narrow
  always_comb begin
    prod_full  = PW'(x_p0) * PW'(m_p0);
    prod_shift = prod_full >>> FRAC;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      prod_p1 <= narrow(prod_shift);
      c_p1    <= c_p0;
    end
  end

  // Stage 3: add intercept, narrow into out_data
  always_comb begin
    sum_w = (BITSIZE+1)'(prod_p1) + (BITSIZE+1)'(c_p1);
  end

endmodule
